song_sequencer: RTL and testbench

Playback controller that sits directly upstream of the song memory. It drives the memory's 6-bit read address and consumes the 12-bit note word returned combinationally. It holds each note for its encoded number of beats, then steps to the next address. Downstream tone generation receives a registered pitch, a gate (`note_on`) and a one-cycle strobe per new note.

---
 rtl/song_sequencer.sv | 146 ++++++++++++++
 tb/tb_song_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Song memory playback controller: walks the note words at Addr, holds each note
// for its beat count, and presents a registered pitch, gate and per-note strobe.
module song_sequencer #(
    parameter int SONG_LEN       = 12,
    parameter int ENC_LEN        = 12,
    parameter int TICKS_PER_BEAT = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               play,
    input  logic               restart,
    input  logic               loop,
    output logic [5:0]         Addr,
    input  logic [ENC_LEN-1:0] note_data,
    output logic [5:0]         pitch,
    output logic               note_on,
    output logic               note_strobe,
    output logic               done
);

    localparam int TW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BEAT - 1);
    localparam logic [5:0]    ADDR_LAST = 6'(SONG_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [5:0]    addr_n;
    logic [TW-1:0] tick, tick_n;
    logic [5:0]    beats_left, beats_n;
    logic [5:0]    pitch_n;
    logic          note_on_n, strobe_n, done_n;
    logic          take_end;
    logic [5:0]    word_pitch, word_dur;

    assign word_pitch = note_data[11:6];
    assign word_dur   = note_data[5:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            Addr        <= 6'd0;
            tick        <= '0;
            beats_left  <= 6'd0;
            pitch       <= 6'd0;
            note_on     <= 1'b0;
            note_strobe <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            Addr        <= addr_n;
            tick        <= tick_n;
            beats_left  <= beats_n;
            pitch       <= pitch_n;
            note_on     <= note_on_n;
            note_strobe <= strobe_n;
            done        <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        addr_n    = Addr;
        tick_n    = tick;
        beats_n   = beats_left;
        pitch_n   = pitch;
        note_on_n = note_on;
        strobe_n  = 1'b0;
        done_n    = done;
        take_end  = 1'b0;

        if (restart) begin
            state_n   = play ? S_LOAD : S_IDLE;
            addr_n    = 6'd0;
            tick_n    = '0;
            beats_n   = 6'd0;
            pitch_n   = 6'd0;
            note_on_n = 1'b0;
            done_n    = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (play) state_n = S_LOAD;
                end
                S_LOAD: begin
                    // LOAD ignores play: the note is always committed once sampled
                    note_on_n = 1'b0;
                    if (word_dur == 6'd0) begin
                        take_end = 1'b1;
                    end else begin
                        pitch_n   = word_pitch;
                        beats_n   = word_dur;
                        tick_n    = '0;
                        note_on_n = (word_pitch != 6'd0);
                        strobe_n  = 1'b1;
                        state_n   = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (play) begin
                        note_on_n = (pitch != 6'd0);
                        if (tick == TICK_LAST) begin
                            tick_n  = '0;
                            beats_n = beats_left - 6'd1;
                            if (beats_left == 6'd1) begin
                                note_on_n = 1'b0;
                                if (Addr == ADDR_LAST) begin
                                    take_end = 1'b1;
                                end else begin
                                    addr_n  = Addr + 6'd1;
                                    state_n = S_LOAD;
                                end
                            end
                        end else begin
                            tick_n = tick + TW'(1);
                        end
                    end else begin
                        // paused: counters hold, gate drops, pitch is kept for resume
                        note_on_n = 1'b0;
                    end
                end
                S_DONE: begin
                    state_n = S_DONE;
                end
            endcase

            if (take_end) begin
                note_on_n = 1'b0;
                if (loop) begin
                    addr_n  = 6'd0;
                    state_n = S_LOAD;
                end else begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                    pitch_n = 6'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a 3-word song and 4 ticks per beat.
module tb_song_sequencer;

    localparam int SONG_LEN = 3;
    localparam int TPB      = 4;

    logic        clk;
    logic        rst_n;
    logic        play;
    logic        restart;
    logic        loop;
    logic [5:0]  addr;
    logic [11:0] note_data;
    logic [5:0]  pitch;
    logic        note_on;
    logic        note_strobe;
    logic        done;

    logic [11:0] mem [0:63];
    int vectors     = 0;
    int miscompares = 0;

    assign note_data = mem[addr];

    song_sequencer #(
        .SONG_LEN(SONG_LEN),
        .ENC_LEN(12),
        .TICKS_PER_BEAT(TPB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .play(play),
        .restart(restart),
        .loop(loop),
        .Addr(addr),
        .note_data(note_data),
        .pitch(pitch),
        .note_on(note_on),
        .note_strobe(note_strobe),
        .done(done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_song(input logic [11:0] w0, input logic [11:0] w1, input logic [11:0] w2);
        for (int i = 0; i < 64; i++) mem[i] = 12'h000;
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = w2;
    endtask

    task automatic kick();
        restart = 1'b1;
        play    = 1'b1;
        step(1);
        restart = 1'b0;
    endtask

    task automatic wait_strobe(input int budget, output bit seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            cycles++;
            if (note_strobe) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; play = 1'b0; restart = 1'b0; loop = 1'b0;
        load_song(12'h041, 12'h082, 12'h000);
        #17;
        vectors++;
        if ({addr, pitch, note_on, note_strobe, done} !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, expected 0", {addr, pitch, note_on, note_strobe, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        vectors++;
        if ({addr, note_on, note_strobe, done} !== 9'h0) begin
            miscompares++;
            $display("FAIL idle_hold: got %h, expected 0", {addr, note_on, note_strobe, done});
        end
    endtask

    task automatic test_playback();
        int bad;
        play = 1'b1;
        step(1);
        vectors++;
        if ({note_strobe, note_on} !== 2'b00) begin
            miscompares++;
            $display("FAIL load_cycle: got %b, expected 00", {note_strobe, note_on});
        end
        step(1);
        vectors++;
        if ({note_strobe, note_on, pitch, addr} !== {1'b1, 1'b1, 6'd1, 6'd0}) begin
            miscompares++;
            $display("FAIL note0_start: got %h, expected %h", {note_strobe, note_on, pitch, addr}, {1'b1, 1'b1, 6'd1, 6'd0});
        end
        step(4);
        vectors++;
        if ({addr, note_on, note_strobe} !== {6'd1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL gap: got %h, expected %h", {addr, note_on, note_strobe}, {6'd1, 1'b0, 1'b0});
        end
        step(1);
        vectors++;
        if ({note_strobe, note_on, pitch} !== {1'b1, 1'b1, 6'd2}) begin
            miscompares++;
            $display("FAIL note1_start: got %h, expected %h", {note_strobe, note_on, pitch}, {1'b1, 1'b1, 6'd2});
        end
        bad = 0;
        for (int j = 0; j < 7; j++) begin
            step(1);
            if (!(note_on === 1'b1 && note_strobe === 1'b0)) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL note1_hold: got %0d bad cycles, expected 0", bad);
        end
        step(1);
        vectors++;
        if ({addr, note_on, done} !== {6'd2, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL marker_load: got %h, expected %h", {addr, note_on, done}, {6'd2, 1'b0, 1'b0});
        end
        step(1);
        vectors++;
        if ({done, pitch, note_on, note_strobe} !== {1'b1, 6'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL done_entry: got %h, expected %h", {done, pitch, note_on, note_strobe}, {1'b1, 6'd0, 1'b0, 1'b0});
        end
        step(3);
        vectors++;
        if ({done, addr, note_strobe} !== {1'b1, 6'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL done_hold: got %h, expected %h", {done, addr, note_strobe}, {1'b1, 6'd2, 1'b0});
        end
    endtask

    task automatic test_restart();
        int strobes;
        kick();
        vectors++;
        if ({addr, done, note_on, pitch} !== 14'h0) begin
            miscompares++;
            $display("FAIL restart_done: got %h, expected 0", {addr, done, note_on, pitch});
        end
        step(1);
        vectors++;
        if ({note_strobe, pitch, addr} !== {1'b1, 6'd1, 6'd0}) begin
            miscompares++;
            $display("FAIL restart_load: got %h, expected %h", {note_strobe, pitch, addr}, {1'b1, 6'd1, 6'd0});
        end
        step(5);
        step(3);
        vectors++;
        if ({addr, note_on, pitch} !== {6'd1, 1'b1, 6'd2}) begin
            miscompares++;
            $display("FAIL mid_note_pre: got %h, expected %h", {addr, note_on, pitch}, {6'd1, 1'b1, 6'd2});
        end
        kick();
        vectors++;
        if ({addr, note_on, pitch, done} !== 14'h0) begin
            miscompares++;
            $display("FAIL restart_mid: got %h, expected 0", {addr, note_on, pitch, done});
        end
        step(1);
        vectors++;
        if ({note_strobe, pitch, addr} !== {1'b1, 6'd1, 6'd0}) begin
            miscompares++;
            $display("FAIL restart_mid_load: got %h, expected %h", {note_strobe, pitch, addr}, {1'b1, 6'd1, 6'd0});
        end
        step(3);
        kick();
        vectors++;
        if ({addr, note_on} !== 7'h0) begin
            miscompares++;
            $display("FAIL restart_at_end: got %h, expected 0", {addr, note_on});
        end
        step(1);
        vectors++;
        if ({note_strobe, addr, pitch} !== {1'b1, 6'd0, 6'd1}) begin
            miscompares++;
            $display("FAIL restart_at_end_load: got %h, expected %h", {note_strobe, addr, pitch}, {1'b1, 6'd0, 6'd1});
        end
        restart = 1'b1;
        play    = 1'b0;
        step(1);
        restart = 1'b0;
        strobes = 0;
        for (int j = 0; j < 4; j++) begin
            step(1);
            if (note_strobe !== 1'b0 || note_on !== 1'b0 || addr !== 6'd0) strobes++;
        end
        vectors++;
        if (strobes !== 0) begin
            miscompares++;
            $display("FAIL restart_to_idle: got %0d active cycles, expected 0", strobes);
        end
        play = 1'b1;
        step(2);
        vectors++;
        if (note_strobe !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_to_play: got %b, expected 1", note_strobe);
        end
    endtask

    task automatic test_rest();
        int bad;
        load_song(12'h002, 12'h041, 12'h000);
        loop = 1'b0;
        kick();
        step(1);
        vectors++;
        if ({note_strobe, pitch, note_on} !== {1'b1, 6'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL rest_start: got %h, expected %h", {note_strobe, pitch, note_on}, {1'b1, 6'd0, 1'b0});
        end
        bad = 0;
        for (int j = 0; j < 7; j++) begin
            step(1);
            if (note_on !== 1'b0 || addr !== 6'd0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL rest_hold: got %0d bad cycles, expected 0", bad);
        end
        step(1);
        vectors++;
        if ({addr, note_on} !== {6'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL rest_end: got %h, expected %h", {addr, note_on}, {6'd1, 1'b0});
        end
        step(1);
        vectors++;
        if ({note_strobe, pitch, note_on} !== {1'b1, 6'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL after_rest: got %h, expected %h", {note_strobe, pitch, note_on}, {1'b1, 6'd1, 1'b1});
        end
    endtask

    task automatic test_pause();
        int bad;
        load_song(12'h042, 12'h041, 12'h000);
        kick();
        step(1);
        step(2);
        play = 1'b0;
        bad = 0;
        for (int j = 0; j < 10; j++) begin
            step(1);
            if (note_on !== 1'b0 || addr !== 6'd0 || pitch !== 6'd1) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL pause_hold: got %0d bad cycles, expected 0", bad);
        end
        play = 1'b1;
        step(1);
        vectors++;
        if (note_on !== 1'b1) begin
            miscompares++;
            $display("FAIL pause_resume: got %b, expected 1", note_on);
        end
        step(4);
        vectors++;
        if (addr !== 6'd0) begin
            miscompares++;
            $display("FAIL pause_not_early: got %0d, expected 0", addr);
        end
        step(1);
        vectors++;
        if ({addr, note_on} !== {6'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL pause_end: got %h, expected %h", {addr, note_on}, {6'd1, 1'b0});
        end
    endtask

    task automatic test_loop_wrap();
        bit seen;
        int cycles;
        load_song(12'h041, 12'h041, 12'h041);
        loop = 1'b1;
        kick();
        for (int k = 0; k < 7; k++) begin
            wait_strobe(12, seen, cycles);
            vectors++;
            if (!seen) begin
                miscompares++;
                $display("FAIL wrap_strobe_%0d: got none, expected strobe", k);
            end else if ({addr, done} !== {6'(k % 3), 1'b0}) begin
                miscompares++;
                $display("FAIL wrap_addr_%0d: got %h, expected %h", k, {addr, done}, {6'(k % 3), 1'b0});
            end
        end
        load_song(12'h041, 12'h000, 12'h000);
        kick();
        for (int k = 0; k < 3; k++) begin
            wait_strobe(12, seen, cycles);
            vectors++;
            if (!seen || addr !== 6'd0 || done !== 1'b0 || (k > 0 && cycles !== 6)) begin
                miscompares++;
                $display("FAIL marker_wrap_%0d: got seen=%0d addr=%0d cycles=%0d, expected seen=1 addr=0 cycles=6", k, seen, addr, cycles);
            end
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        int cycles;
        load_song(12'h041, 12'h082, 12'h041);
        loop = 1'b1;
        kick();
        wait_strobe(12, seen, cycles);
        wait_strobe(12, seen, cycles);
        step(2);
        vectors++;
        if ({addr, note_on} !== {6'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL pre_reset: got %h, expected %h", {addr, note_on}, {6'd1, 1'b1});
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({addr, pitch, note_on, note_strobe, done} !== 15'h0) begin
            miscompares++;
            $display("FAIL async_reset: got %h, expected 0", {addr, pitch, note_on, note_strobe, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        play  = 1'b1;
        step(1);
        vectors++;
        if (note_strobe !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_load: got %b, expected 0", note_strobe);
        end
        step(1);
        vectors++;
        if ({note_strobe, addr, pitch} !== {1'b1, 6'd0, 6'd1}) begin
            miscompares++;
            $display("FAIL post_reset_strobe: got %h, expected %h", {note_strobe, addr, pitch}, {1'b1, 6'd0, 6'd1});
        end
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_playback();
        test_restart();
        test_rest();
        test_pause();
        test_loop_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
